mealy_bit_serializer: RTL

Parallel-to-serial front end that feeds the serial `x` input of the team's Mealy sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a registered serial line. A one-word holding register double-buffers the shifter, so back-to-back words form a gapless bit stream. Downstream, the detector samples `x` on the next rising edge.

---
 rtl/mealy_bit_serializer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mealy_bit_serializer.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// mealy_bit_serializer
//
// Parallel-to-serial front end for the Mealy sequence detector. WIDTH-bit
// words arrive over a valid/ready handshake. They are parked in a one-word
// holding register, then shifted out one bit per clock on a registered serial
// line. The holding register double-buffers the shifter. A word held by the
// time the current word's last bit goes out is loaded on the very next edge,
// so consecutive words form a gapless bit stream.
//
// Parameters
//   WIDTH       word length in bits (>= 2)
//   MSB_FIRST   1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//   IDLE_BIT    level driven on x while no data bit is presented
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   din          in   parallel word to serialize
//   din_valid    in   din holds a word
//   din_ready    out  holding register empty (combinational, = ~hold_valid)
//   x            out  registered serial bit to the detector
//   x_valid      out  x carries a data bit this cycle
//   frame_start  out  one-cycle pulse aligned with the first bit of a word
//   busy         out  shifter active or holding register full (registered)
// ----------------------------------------------------------------------------
module mealy_bit_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter logic        IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             x,
   output logic             x_valid,
   output logic             frame_start,
   output logic             busy
);

   localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic {
      ST_IDLE,
      ST_SHIFT
   } state_t;

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   state_t           r_state;
   logic [WIDTH-1:0] r_hold;
   logic             r_hold_valid;
   logic [WIDTH-1:0] r_shift;
   logic [CNT_W-1:0] r_bit_cnt;
   logic             r_x;
   logic             r_x_valid;
   logic             r_frame_start;
   logic             r_busy;

   // -------------------------------------------------------------------------
   // Combinational next values
   // -------------------------------------------------------------------------
   state_t           w_state_nxt;
   logic             w_accept;
   logic             w_load_cond;
   logic             w_load;
   logic             w_hold_valid_nxt;
   logic [WIDTH-1:0] w_shift_nxt;
   logic [CNT_W-1:0] w_bit_cnt_nxt;
   logic             w_x_nxt;
   logic             w_x_valid_nxt;
   logic             w_frame_start_nxt;
   logic             w_busy_nxt;

   // Bit of a shifter image that sits at the output end.
   function automatic logic output_end(input logic [WIDTH-1:0] v);
      return MSB_FIRST ? v[WIDTH-1] : v[0];
   endfunction

   // Handshake: the holding register takes a word only when it is empty.
   assign din_ready = ~r_hold_valid;
   assign w_accept  = din_valid & ~r_hold_valid;

   // The shifter can take a new word when it is idle or presenting its last
   // bit. Accept needs an empty hold and load needs a full one, so the two
   // never coincide and the hold update below needs no priority rule.
   assign w_load_cond = (r_state == ST_IDLE) || (r_bit_cnt == LAST_CNT);
   assign w_load      = w_load_cond & r_hold_valid;

   always_comb begin
      w_hold_valid_nxt = r_hold_valid;
      if (w_accept) begin
         w_hold_valid_nxt = 1'b1;
      end else if (w_load) begin
         w_hold_valid_nxt = 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // FSM process 1: state register
   // -------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // FSM process 2: next-state logic
   // -------------------------------------------------------------------------
   // NOTE: every combinational output gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      if (w_load_cond) begin
         w_state_nxt = r_hold_valid ? ST_SHIFT : ST_IDLE;
      end
   end

   // -------------------------------------------------------------------------
   // FSM process 3: output / datapath logic (values registered below)
   // -------------------------------------------------------------------------
   always_comb begin
      w_shift_nxt       = r_shift;
      w_bit_cnt_nxt     = r_bit_cnt;
      w_x_nxt           = r_x;
      w_x_valid_nxt     = r_x_valid;
      w_frame_start_nxt = 1'b0;

      if (w_load) begin
         // Start a new word: its first bit goes out with the frame marker.
         w_shift_nxt       = r_hold;
         w_bit_cnt_nxt     = '0;
         w_x_nxt           = output_end(r_hold);
         w_x_valid_nxt     = 1'b1;
         w_frame_start_nxt = 1'b1;
      end else if (w_load_cond) begin
         // Last bit done and nothing waiting: line goes idle.
         w_x_nxt       = IDLE_BIT;
         w_x_valid_nxt = 1'b0;
      end else begin
         // Mid-word: move the next bit to the output end.
         w_shift_nxt   = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
         w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
         w_x_nxt       = output_end(w_shift_nxt);
         w_x_valid_nxt = 1'b1;
      end

      // busy is registered from the next-state view so it lines up with x.
      w_busy_nxt = (w_state_nxt == ST_SHIFT) | w_hold_valid_nxt;
   end

   // -------------------------------------------------------------------------
   // Datapath and output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hold_valid  <= 1'b0;
         r_shift       <= '0;
         r_bit_cnt     <= '0;
         r_x           <= IDLE_BIT;
         r_x_valid     <= 1'b0;
         r_frame_start <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_hold_valid  <= w_hold_valid_nxt;
         r_shift       <= w_shift_nxt;
         r_bit_cnt     <= w_bit_cnt_nxt;
         r_x           <= w_x_nxt;
         r_x_valid     <= w_x_valid_nxt;
         r_frame_start <= w_frame_start_nxt;
         r_busy        <= w_busy_nxt;
      end
   end

   // NOTE: the hold data register is deliberately left out of reset; its
   // content is only ever consumed while r_hold_valid is set, and that flag
   // is reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_hold <= din;
      end
   end

   assign x           = r_x;
   assign x_valid     = r_x_valid;
   assign frame_start = r_frame_start;
   assign busy        = r_busy;

endmodule
